// File: rtl/ahb_alu_pkg.sv
// Shared definitions for the AHB-Lite ALU master.
//   - AHB encodings for HTRANS and HBURST
//   - HSIZE helper derived from the bus width
//   - ALU opcode enum (0-12) and the master FSM state enum
package ahb_alu_pkg;

   localparam logic [1:0] HtransIdle   = 2'b00;
   localparam logic [1:0] HtransNonseq = 2'b10;
   localparam logic [2:0] HburstSingle = 3'b000;

   // One full-width beat per transfer: word for 32-bit, doubleword for 64-bit.
   function automatic logic [2:0] hsize_f(int unsigned data_w);
      return (data_w == 64) ? 3'b011 : 3'b010;
   endfunction

   typedef enum logic [3:0] {
      OpAdd   = 4'd0,
      OpSub   = 4'd1,
      OpAnd   = 4'd2,
      OpOr    = 4'd3,
      OpXor   = 4'd4,
      OpNot   = 4'd5,
      OpShl   = 4'd6,
      OpShr   = 4'd7,
      OpSra   = 4'd8,
      OpEq    = 4'd9,
      OpLtu   = 4'd10,
      OpMul   = 4'd11,
      OpPassB = 4'd12
   } alu_op_e;

   localparam logic [3:0] OpLast = 4'd12;

   typedef enum logic [2:0] {
      StIdle,
      StAddrA,
      StAddrB,
      StDataB,
      StExec,
      StAddrW,
      StDataW,
      StDone
   } state_e;

endpackage

// File: rtl/ahb_alu_core.sv
// Combinational ALU used by the AHB ALU master.
// Ports:
//   a_i, b_i  : operands (DATA_W bits)
//   op_i      : operation select
//   result_o  : result truncated to DATA_W bits; shift amount is b_i[log2(DATA_W)-1:0]
module ahb_alu_core
   import ahb_alu_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  alu_op_e           op_i,
   output logic [DATA_W-1:0] result_o
);

   localparam int unsigned ShW = $clog2(DATA_W);

   logic [ShW-1:0] sh;

   assign sh = b_i[ShW-1:0];

   always_comb begin
      result_o = '0;
      case (op_i)
         OpAdd:   result_o = a_i + b_i;
         OpSub:   result_o = a_i - b_i;
         OpAnd:   result_o = a_i & b_i;
         OpOr:    result_o = a_i | b_i;
         OpXor:   result_o = a_i ^ b_i;
         OpNot:   result_o = ~a_i;
         OpShl:   result_o = a_i << sh;
         OpShr:   result_o = a_i >> sh;
         OpSra:   result_o = $signed(a_i) >>> sh;
         OpEq:    result_o = {{(DATA_W-1){1'b0}}, a_i == b_i};
         OpLtu:   result_o = {{(DATA_W-1){1'b0}}, a_i < b_i};
         OpMul:   result_o = a_i * b_i;
         OpPassB: result_o = b_i;
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/ahb_alu_master.sv
// AHB-Lite master with integrated ALU: reads operands A and B, executes the
// opcode, writes the result to D, then pulses done_valid with status.
// Ports:
//   HCLK, HRESTn                         : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_opcode,
//   cmd_addr_a/b/d                       : command handshake and fields
//   done_valid, done_err, done_result    : completion pulse, error flag, result
//   HADDR, HWDATA, HRDATA, HWRITE, HSIZE,
//   HBURST, HTRANS, HREADY, HRESP        : AHB-Lite master interface
// Build option: define AHB_ALU_MASTER_ERR_RETRY_EN to reissue a transfer once
// after an ERROR response instead of aborting the command.
module ahb_alu_master
   import ahb_alu_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              HCLK,
   input  logic              HRESTn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_opcode,
   input  logic [ADDR_W-1:0] cmd_addr_a,
   input  logic [ADDR_W-1:0] cmd_addr_b,
   input  logic [ADDR_W-1:0] cmd_addr_d,
   output logic              done_valid,
   output logic              done_err,
   output logic [DATA_W-1:0] done_result,
   output logic [ADDR_W-1:0] HADDR,
   output logic [DATA_W-1:0] HWDATA,
   input  logic [DATA_W-1:0] HRDATA,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [2:0]        HBURST,
   output logic [1:0]        HTRANS,
   input  logic              HREADY,
   input  logic              HRESP
);

`ifdef AHB_ALU_MASTER_ERR_RETRY_EN
   localparam bit RetryEn = 1'b1;
`else
   localparam bit RetryEn = 1'b0;
`endif

   localparam int unsigned AlignW = $clog2(DATA_W / 8);

   state_e            state_q, state_d;
   alu_op_e           opcode_q, opcode_d;
   logic [ADDR_W-1:0] addr_a_q, addr_a_d;
   logic [ADDR_W-1:0] addr_b_q, addr_b_d;
   logic [ADDR_W-1:0] addr_d_q, addr_d_d;
   logic [DATA_W-1:0] op_a_q, op_a_d;
   logic [DATA_W-1:0] op_b_q, op_b_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [DATA_W-1:0] done_result_q, done_result_d;
   logic              err_q, err_d;
   logic              retried_q, retried_d;  // current transfer already reissued once
   logic              skip_a_q, skip_a_d;    // B reissue: no A data phase in flight

   logic [DATA_W-1:0] alu_result;
   logic              cmd_ok;
   logic              retry_ok;
   logic              a_err;

   ahb_alu_core #(
      .DATA_W(DATA_W)
   ) u_core (
      .a_i     (op_a_q),
      .b_i     (op_b_q),
      .op_i    (opcode_q),
      .result_o(alu_result)
   );

   assign cmd_ready   = HRESTn && (state_q == StIdle);
   assign done_valid  = (state_q == StDone);
   assign done_err    = done_valid && err_q;
   assign done_result = done_result_q;
   assign HSIZE       = hsize_f(DATA_W);
   assign HBURST      = HburstSingle;

   assign cmd_ok = (cmd_opcode <= OpLast) &&
                   (cmd_addr_a[AlignW-1:0] == '0) &&
                   (cmd_addr_b[AlignW-1:0] == '0) &&
                   (cmd_addr_d[AlignW-1:0] == '0);

   assign retry_ok = RetryEn && !retried_q;
   assign a_err    = !skip_a_q && HRESP;

   always_comb begin
      state_d       = state_q;
      opcode_d      = opcode_q;
      addr_a_d      = addr_a_q;
      addr_b_d      = addr_b_q;
      addr_d_d      = addr_d_q;
      op_a_d        = op_a_q;
      op_b_d        = op_b_q;
      result_d      = result_q;
      done_result_d = done_result_q;
      err_d         = err_q;
      retried_d     = retried_q;
      skip_a_d      = skip_a_q;
      HTRANS        = HtransIdle;
      HADDR         = '0;
      HWRITE        = 1'b0;
      HWDATA        = '0;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid && cmd_ready) begin
               opcode_d  = alu_op_e'(cmd_opcode);
               addr_a_d  = cmd_addr_a;
               addr_b_d  = cmd_addr_b;
               addr_d_d  = cmd_addr_d;
               retried_d = 1'b0;
               skip_a_d  = 1'b0;
               err_d     = !cmd_ok;
               state_d   = cmd_ok ? StAddrA : StDone;
            end
         end
         StAddrA: begin
            HTRANS = HtransNonseq;
            HADDR  = addr_a_q;
            if (HREADY) begin
               state_d = StAddrB;
            end
         end
         StAddrB: begin
            // An ERROR on the A data phase withdraws the pending B address.
            HTRANS = a_err ? HtransIdle : HtransNonseq;
            HADDR  = addr_b_q;
            if (HREADY) begin
               if (a_err) begin
                  if (retry_ok) begin
                     retried_d = 1'b1;
                     state_d   = StAddrA;
                  end else begin
                     err_d   = 1'b1;
                     state_d = StDone;
                  end
               end else begin
                  if (!skip_a_q) begin
                     op_a_d    = HRDATA;
                     retried_d = 1'b0;
                  end
                  state_d = StDataB;
               end
            end
         end
         StDataB: begin
            if (HREADY) begin
               if (HRESP) begin
                  if (retry_ok) begin
                     retried_d = 1'b1;
                     skip_a_d  = 1'b1;
                     state_d   = StAddrB;
                  end else begin
                     err_d   = 1'b1;
                     state_d = StDone;
                  end
               end else begin
                  op_b_d    = HRDATA;
                  retried_d = 1'b0;
                  skip_a_d  = 1'b0;
                  state_d   = StExec;
               end
            end
         end
         StExec: begin
            result_d = alu_result;
            state_d  = StAddrW;
         end
         StAddrW: begin
            HTRANS = HtransNonseq;
            HADDR  = addr_d_q;
            HWRITE = 1'b1;
            if (HREADY) begin
               state_d = StDataW;
            end
         end
         StDataW: begin
            HADDR  = addr_d_q;
            HWDATA = result_q;
            if (HREADY) begin
               if (HRESP) begin
                  if (retry_ok) begin
                     retried_d = 1'b1;
                     state_d   = StAddrW;
                  end else begin
                     err_d   = 1'b1;
                     state_d = StDone;
                  end
               end else begin
                  retried_d = 1'b0;
                  state_d   = StDone;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if ((state_d == StDone) && (state_q != StDone)) begin
         done_result_d = err_d ? '0 : result_q;
      end
   end

   always_ff @(posedge HCLK or negedge HRESTn) begin
      if (!HRESTn) begin
         state_q       <= StIdle;
         opcode_q      <= OpAdd;
         addr_a_q      <= '0;
         addr_b_q      <= '0;
         addr_d_q      <= '0;
         op_a_q        <= '0;
         op_b_q        <= '0;
         result_q      <= '0;
         done_result_q <= '0;
         err_q         <= 1'b0;
         retried_q     <= 1'b0;
         skip_a_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         opcode_q      <= opcode_d;
         addr_a_q      <= addr_a_d;
         addr_b_q      <= addr_b_d;
         addr_d_q      <= addr_d_d;
         op_a_q        <= op_a_d;
         op_b_q        <= op_b_d;
         result_q      <= result_d;
         done_result_q <= done_result_d;
         err_q         <= err_d;
         retried_q     <= retried_d;
         skip_a_q      <= skip_a_d;
      end
   end

endmodule

// File: tb/tb_ahb_alu_master.sv
// Self-checking bench for ahb_alu_master: a 32-bit instance on a configurable
// AHB slave model (wait states, ERROR injection) and a 64-bit instance on a
// zero-wait slave. Expected completions go into a queue; a negedge monitor
// pops and compares whenever done_valid is seen.
module tb_ahb_alu_master;
   import ahb_alu_pkg::*;

   logic HCLK = 1'b0;
   always #5 HCLK = ~HCLK;
   logic HRESTn;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- 32-bit DUT ----------------
   logic        cmd_valid, cmd_ready;
   logic [3:0]  cmd_opcode;
   logic [31:0] cmd_addr_a, cmd_addr_b, cmd_addr_d;
   logic        done_valid, done_err;
   logic [31:0] done_result;
   logic [31:0] haddr, hwdata, hrdata;
   logic        hwrite, hready, hresp;
   logic [2:0]  hsize, hburst;
   logic [1:0]  htrans;

   ahb_alu_master #(.DATA_W(32), .ADDR_W(32)) dut (
      .HCLK(HCLK), .HRESTn(HRESTn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
      .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_addr_d(cmd_addr_d),
      .done_valid(done_valid), .done_err(done_err), .done_result(done_result),
      .HADDR(haddr), .HWDATA(hwdata), .HRDATA(hrdata), .HWRITE(hwrite),
      .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HREADY(hready), .HRESP(hresp)
   );

   // Slave model: wait_n wait states per data phase; ERROR on err_addr while budget lasts.
   logic [31:0] mem [0:255];
   logic        dp_valid = 1'b0, dp_write = 1'b0, dp_err = 1'b0;
   logic [31:0] dp_addr = '0;
   int          dp_cnt = 0;
   int          wait_n = 0;
   logic [31:0] err_addr = 32'hFFFF_FFF0;
   int          err_budget = 0, err_used = 0;
   int          nonseq_cnt = 0, wr_cnt = 0;
   logic [31:0] wa0 = '0, wa1 = '0, wd0 = '0, wd1 = '0;

   always_comb begin
      hready = 1'b1;
      hresp  = 1'b0;
      if (dp_valid) begin
         if (dp_cnt > 0) begin
            hready = 1'b0;
            hresp  = dp_err && (dp_cnt == 1);
         end else begin
            hresp = dp_err;
         end
      end
      hrdata = (dp_valid && !dp_write && !dp_err) ? mem[dp_addr[9:2]] : 32'h0;
   end

   always @(posedge HCLK or negedge HRESTn) begin
      if (!HRESTn) begin
         dp_valid <= 1'b0;
         dp_err   <= 1'b0;
         dp_cnt   <= 0;
      end else if (hready) begin
         if (dp_valid && dp_write) begin
            wd1 <= wd0;
            wd0 <= hwdata;
         end
         if (htrans == 2'b10) begin
            nonseq_cnt <= nonseq_cnt + 1;
            dp_valid   <= 1'b1;
            dp_addr    <= haddr;
            dp_write   <= hwrite;
            if (hwrite) begin
               wr_cnt <= wr_cnt + 1;
               wa1    <= wa0;
               wa0    <= haddr;
            end
            if (haddr == err_addr && err_used < err_budget) begin
               dp_err   <= 1'b1;
               dp_cnt   <= wait_n + 1;
               err_used <= err_used + 1;
            end else begin
               dp_err <= 1'b0;
               dp_cnt <= wait_n;
            end
         end else begin
            dp_valid <= 1'b0;
         end
      end else begin
         dp_cnt <= dp_cnt - 1;
      end
   end

   // ---------------- 64-bit DUT ----------------
   logic        c64_valid, c64_ready;
   logic [3:0]  c64_opcode;
   logic [31:0] c64_a, c64_b, c64_d;
   logic        d64_valid, d64_err;
   logic [63:0] d64_result;
   logic [31:0] haddr64;
   logic [63:0] hwdata64, rd64 = '0, wd64_cap = '0;
   logic        hwrite64, pend64_w = 1'b0;
   logic        hready64 = 1'b1, hresp64 = 1'b0;
   logic [2:0]  hsize64, hburst64;
   logic [1:0]  htrans64;
   int          wr64_cnt = 0;

   ahb_alu_master #(.DATA_W(64), .ADDR_W(32)) dut64 (
      .HCLK(HCLK), .HRESTn(HRESTn),
      .cmd_valid(c64_valid), .cmd_ready(c64_ready), .cmd_opcode(c64_opcode),
      .cmd_addr_a(c64_a), .cmd_addr_b(c64_b), .cmd_addr_d(c64_d),
      .done_valid(d64_valid), .done_err(d64_err), .done_result(d64_result),
      .HADDR(haddr64), .HWDATA(hwdata64), .HRDATA(rd64), .HWRITE(hwrite64),
      .HSIZE(hsize64), .HBURST(hburst64), .HTRANS(htrans64), .HREADY(hready64),
      .HRESP(hresp64)
   );

   always @(posedge HCLK) begin
      if (htrans64 == 2'b10 && !hwrite64) begin
         rd64 <= (haddr64 == 32'h100) ? 64'h8000_0000_0000_0000 : 64'd4;
      end
      pend64_w <= (htrans64 == 2'b10) && hwrite64;
      if (pend64_w) begin
         wd64_cap <= hwdata64;
         wr64_cnt <= wr64_cnt + 1;
      end
   end

   // ---------------- Scoreboard / monitors ----------------
   typedef struct {
      logic        err;
      logic [31:0] res;
      int          lat;
   } exp_t;
   exp_t        exp_q[$];
   exp_t        e;
   logic [63:0] exp64_q[$];
   logic [63:0] e64;

   int cyc = 0;
   always @(posedge HCLK) cyc <= cyc + 1;

   int          acc_cyc = 0;
   logic        prev_wait = 1'b0;
   logic [31:0] p_haddr, p_hwdata;
   logic [1:0]  p_htrans;
   logic        p_hwrite;

   always @(negedge HCLK) begin
      if (!HRESTn) begin
         prev_wait = 1'b0;
      end else begin
         if (cmd_valid && cmd_ready) acc_cyc = cyc;
         if (prev_wait && !(!hready && hresp)) begin
            check("wait_haddr", haddr, p_haddr);
            check("wait_htrans", htrans, p_htrans);
            check("wait_hwrite", hwrite, p_hwrite);
            check("wait_hwdata", hwdata, p_hwdata);
         end
         if (!hready && hresp) check("err_cycle_htrans_idle", htrans, 2'b00);
         prev_wait = !hready && !hresp;
         p_haddr   = haddr;
         p_hwdata  = hwdata;
         p_htrans  = htrans;
         p_hwrite  = hwrite;
         if (done_valid) begin
            check("done_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("done_err", done_err, e.err);
               check("done_result", done_result, e.res);
               check("done_latency", cyc - acc_cyc, e.lat);
            end
         end
      end
   end

   always @(negedge HCLK) begin
      if (HRESTn && d64_valid) begin
         check("d64_expected", exp64_q.size() != 0, 1'b1);
         if (exp64_q.size() != 0) begin
            e64 = exp64_q.pop_front();
            check("d64_result", d64_result, e64);
            check("d64_err", d64_err, 1'b0);
         end
      end
   end

   // ---------------- Stimulus ----------------
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] d, input bit push, input logic err,
                        input logic [31:0] res, input int lat);
      int n;
      if (push) exp_q.push_back('{err: err, res: res, lat: lat});
      @(posedge HCLK); #1;
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      cmd_addr_a = a;
      cmd_addr_b = b;
      cmd_addr_d = d;
      n = 0;
      do begin
         @(negedge HCLK);
         n++;
      end while (!cmd_ready && n < 50);
      check("cmd_accept", cmd_ready, 1'b1);
      @(posedge HCLK); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge HCLK);
         n++;
      end
      check("drain_timeout", exp_q.size(), 0);
      repeat (2) @(negedge HCLK);
   endtask

   logic [3:0]  t_op [12] = '{OpXor, OpShl, OpShr, OpSra, OpLtu, OpLtu, OpMul, OpEq,
                              OpNot, OpPassB, OpAnd, OpOr};
   logic [31:0] t_a [12] = '{32'h120, 32'h120, 32'h120, 32'h120, 32'h100, 32'h104,
                             32'h100, 32'h100, 32'h100, 32'h100, 32'h120, 32'h100};
   logic [31:0] t_b [12] = '{32'h100, 32'h124, 32'h124, 32'h124, 32'h104, 32'h100,
                             32'h104, 32'h100, 32'h104, 32'h124, 32'h124, 32'h104};
   logic [31:0] t_r [12] = '{32'hF0F0_1233, 32'h0F01_2340, 32'h0F0F_0123, 32'hFF0F_0123,
                             32'h0, 32'h1, 32'h23, 32'h1, 32'hFFFF_FFF8, 32'h4, 32'h4,
                             32'h7};

   initial begin
      int n0;
      int w0;
      int n;
      mem[8'h40] = 32'd7;           // 0x100
      mem[8'h41] = 32'd5;           // 0x104
      mem[8'h42] = 32'd3;           // 0x108
      mem[8'h44] = 32'hDEAD_BEEF;   // 0x110
      mem[8'h48] = 32'hF0F0_1234;   // 0x120
      mem[8'h49] = 32'd4;           // 0x124
      HRESTn     = 1'b0;
      cmd_valid  = 1'b0;
      cmd_opcode = '0;
      cmd_addr_a = '0;
      cmd_addr_b = '0;
      cmd_addr_d = '0;
      c64_valid  = 1'b0;
      c64_opcode = '0;
      c64_a      = '0;
      c64_b      = '0;
      c64_d      = '0;

      repeat (2) @(negedge HCLK);
      check("rst_cmd_ready", cmd_ready, 1'b0);
      check("rst_htrans", htrans, 2'b00);
      check("rst_haddr", haddr, 32'h0);
      check("rst_hwdata", hwdata, 32'h0);
      check("rst_hwrite", hwrite, 1'b0);
      check("rst_done_valid", done_valid, 1'b0);
      check("rst_done_err", done_err, 1'b0);
      check("rst_done_result", done_result, 32'h0);
      check("rst_htrans64", htrans64, 2'b00);
      HRESTn = 1'b1;
      @(negedge HCLK);
      check("ready_after_reset", cmd_ready, 1'b1);
      check("hsize32", hsize, 3'b010);
      check("hburst", hburst, 3'b000);
      check("hsize64", hsize64, 3'b011);

      // Zero-wait ADD
      issue(OpAdd, 32'h100, 32'h104, 32'h200, 1'b1, 1'b0, 32'd12, 7);
      drain();
      check("add_wr_addr", wa0, 32'h200);
      check("add_wr_data", wd0, 32'd12);
      repeat (2) @(negedge HCLK);
      check("result_hold", done_result, 32'd12);

      // Two wait states on every data phase
      wait_n = 2;
      issue(OpSub, 32'h108, 32'h104, 32'h200, 1'b1, 1'b0, 32'hFFFF_FFFE, 13);
      drain();
      wait_n = 0;
      check("sub_wr_data", wd0, 32'hFFFF_FFFE);

      // Pre-check failures: no bus activity
      n0 = nonseq_cnt;
      issue(4'd14, 32'h100, 32'h104, 32'h200, 1'b1, 1'b1, 32'h0, 1);
      drain();
      issue(OpAdd, 32'h100, 32'h102, 32'h200, 1'b1, 1'b1, 32'h0, 1);
      drain();
      check("precheck_no_bus", nonseq_cnt, n0);

      for (int i = 0; i < 12; i++) begin
         issue(t_op[i], t_a[i], t_b[i], 32'h200, 1'b1, 1'b0, t_r[i], 7);
         drain();
      end

      // ERROR on read-A: never any write
      w0       = wr_cnt;
      err_addr = 32'h110;
`ifdef AHB_ALU_MASTER_ERR_RETRY_EN
      err_budget = err_used + 2;
      issue(OpAdd, 32'h110, 32'h104, 32'h200, 1'b1, 1'b1, 32'h0, 7);
`else
      err_budget = err_used + 1;
      issue(OpAdd, 32'h110, 32'h104, 32'h200, 1'b1, 1'b1, 32'h0, 4);
`endif
      drain();
      check("erra_no_write", wr_cnt, w0);

`ifdef AHB_ALU_MASTER_ERR_RETRY_EN
      // One ERROR on the write, then OKAY: same address and data reissued
      w0         = wr_cnt;
      err_addr   = 32'h204;
      err_budget = err_used + 1;
      issue(OpAdd, 32'h100, 32'h104, 32'h204, 1'b1, 1'b0, 32'd12, 10);
      drain();
      check("retry_wr_cnt", wr_cnt, w0 + 2);
      check("retry_addr0", wa0, 32'h204);
      check("retry_addr1", wa1, 32'h204);
      check("retry_data0", wd0, 32'd12);
      check("retry_data1", wd1, 32'd12);
      // Two ERRORs on the write: give up
      w0         = wr_cnt;
      err_addr   = 32'h208;
      err_budget = err_used + 2;
      issue(OpAdd, 32'h100, 32'h104, 32'h208, 1'b1, 1'b1, 32'h0, 11);
      drain();
      check("retry2_wr_cnt", wr_cnt, w0 + 2);
`endif

      // Reset during ADDR_B: command dropped, no completion
      issue(OpAdd, 32'h100, 32'h104, 32'h200, 1'b0, 1'b0, 32'h0, 0);
      n = 0;
      do begin
         @(negedge HCLK);
         n++;
      end while (!(htrans == 2'b10 && haddr == 32'h104) && n < 20);
      check("reach_addr_b", haddr, 32'h104);
      #2 HRESTn = 1'b0;
      #1;
      check("midrst_htrans", htrans, 2'b00);
      check("midrst_haddr", haddr, 32'h0);
      check("midrst_cmd_ready", cmd_ready, 1'b0);
      repeat (2) @(negedge HCLK);
      HRESTn = 1'b1;
      @(negedge HCLK);
      check("midrst_ready_after", cmd_ready, 1'b1);
      repeat (10) @(negedge HCLK);

      // 64-bit SRA
      exp64_q.push_back(64'hF800_0000_0000_0000);
      @(posedge HCLK); #1;
      c64_valid  = 1'b1;
      c64_opcode = OpSra;
      c64_a      = 32'h100;
      c64_b      = 32'h108;
      c64_d      = 32'h200;
      n = 0;
      do begin
         @(negedge HCLK);
         n++;
      end while (!c64_ready && n < 50);
      @(posedge HCLK); #1;
      c64_valid = 1'b0;
      n = 0;
      while (exp64_q.size() != 0 && n < 100) begin
         @(negedge HCLK);
         n++;
      end
      check("d64_timeout", exp64_q.size(), 0);
      @(negedge HCLK);
      check("d64_wr_data", wd64_cap, 64'hF800_0000_0000_0000);
      check("d64_wr_cnt", wr64_cnt, 1);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
